// File: rtl/seg7_scan_if.sv
// Display-side bundle between the debug tap and the eight-digit seven-segment driver.
// en is a level qualifier, not a handshake: every cycle it is high the driver scans, every cycle it is low it blanks.
interface seg7_scan_if;
  logic [31:0] data_in;
  logic        en;
  logic [7:0]  led_en;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output data_in,
    output en,
    input  led_en,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  en,
    output led_en,
    output seg,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit time-multiplexed hex display driver with a per-frame snapshot of the value.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seg7_scan #(
  parameter int DIV_CNT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  io_disp
);

  localparam int                 DIV_W    = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV_CNT - 1);

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [31:0]      r_shadow;
  logic [7:0]       r_led_en;
  logic [7:0]       r_seg;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_wrap;
  logic [3:0]       w_nibble;
  logic             w_digit_on;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  assign w_tick   = io_disp.en && (r_div == DIV_LAST);
  assign w_wrap   = w_tick && (r_idx == 3'd7);
  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] w_top;

  // Digit 0 is the floor, so an all-zero value still shows a single "0".
  always_comb begin
    w_top = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_shadow[4*i +: 4] != 4'h0) w_top = 3'(i);
    end
  end

  assign w_digit_on = (r_idx <= w_top);
`else
  assign w_digit_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_idx        <= 3'd0;
      r_shadow     <= 32'h0;
      r_led_en     <= 8'hFF;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else if (!io_disp.en) begin
      r_div        <= '0;
      r_idx        <= 3'd0;
      r_shadow     <= io_disp.data_in;
      r_led_en     <= 8'hFF;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      if (w_tick) begin
        r_div <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      // Snapshot lands on the same edge as the 7->0 wrap, so the new frame starts on fresh data.
      if (w_wrap) r_shadow <= io_disp.data_in;
      r_led_en     <= w_digit_on ? ~(8'b1 << r_idx) : 8'hFF;
      r_seg        <= w_digit_on ? hex_to_seg(w_nibble) : 8'hFF;
      r_frame_done <= w_wrap;
    end
  end

  assign io_disp.led_en     = r_led_en;
  assign io_disp.seg        = r_seg;
  assign io_disp.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a DIV_CNT=4 instance for the main scan and a DIV_CNT=1 instance for the fast corner.
module tb_seg7_scan;

  logic clk;
  logic rst_n;

  seg7_scan_if bus0 ();
  seg7_scan_if bus1 ();

  seg7_scan #(.DIV_CNT(4)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_disp (bus0.slave)
  );

  seg7_scan #(.DIV_CNT(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_disp (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] exp_q[$];
  logic [16:0] exp1_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] led_tbl [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  task automatic push_entry(input logic [16:0] e, input bit sel);
    if (sel) exp1_q.push_back(e);
    else     exp_q.push_back(e);
  endtask

  // Expected outputs for one frame of value v; limit truncates to the first entries.
  task automatic push_frame(input logic [31:0] v, input int dwell, input bit sel, input int limit);
    int         top;
    int         cnt;
    logic [3:0] nib;
    logic [7:0] led;
    logic [7:0] sg;
    logic       fd;
    top = 0;
    for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) top = i;
    cnt = 0;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < dwell; c++) begin
        nib = v[4*d +: 4];
        led = led_tbl[d];
        sg  = hex_tbl[nib];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > top) begin
          led = 8'hFF;
          sg  = 8'hFF;
        end
`endif
        fd = (d == 7) && (c == dwell - 1);
        if (cnt < limit) push_entry({fd, led, sg}, sel);
        cnt++;
      end
    end
  endtask

  task automatic push_blank(input int n, input bit sel);
    for (int i = 0; i < n; i++) push_entry({1'b0, 8'hFF, 8'hFF}, sel);
  endtask

  task automatic compare_now(input string tag, input bit sel);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = sel ? {bus1.frame_done, bus1.led_en, bus1.seg}
              : {bus0.frame_done, bus0.led_en, bus0.seg};
    checks++;
    if ((sel ? exp1_q.size() : exp_q.size()) == 0) begin
      errors++;
      $error("FAIL %s: observed=%h expected=<nothing queued>", tag, obs);
    end else begin
      exp = sel ? exp1_q.pop_front() : exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed {fd,led_en,seg}=%h expected=%h at %0t", tag, obs, exp, $time);
      end
    end
  endtask

  task automatic check_cycles(input int n, input string tag, input bit sel);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      compare_now(tag, sel);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus0.en       = 1'b0;
    bus0.data_in  = 32'h12345678;
    bus1.en       = 1'b0;
    bus1.data_in  = 32'h0;

    // Held in reset: blank outputs, no frame pulse.
    push_blank(2, 1'b0);
    check_cycles(2, "reset_hold", 1'b0);
    rst_n = 1'b1;
    push_blank(2, 1'b0);
    check_cycles(2, "idle_blank", 1'b0);

    // Raise en: digit 0 first, 4-cycle dwell per digit, data change at digit 3 deferred to the next frame.
    bus0.en = 1'b1;
    push_frame(32'h12345678, 4, 1'b0, 32);
    push_frame(32'hFFFFFFFF, 4, 1'b0, 21);
    check_cycles(13, "scan_first", 1'b0);
    bus0.data_in = 32'hFFFFFFFF;
    check_cycles(40, "tear_free", 1'b0);

    // Drop en while digit 5 is lit.
    bus0.en = 1'b0;
    bus0.data_in = 32'h00000A30;
    push_blank(3, 1'b0);
    check_cycles(3, "en_fall", 1'b0);

    bus0.en = 1'b1;
    push_frame(32'h00000A30, 4, 1'b0, 32);
    check_cycles(32, "lead_zero", 1'b0);

    bus0.en = 1'b0;
    bus0.data_in = 32'h0;
    push_blank(2, 1'b0);
    check_cycles(2, "en_low_zero", 1'b0);
    bus0.en = 1'b1;
    push_frame(32'h0, 4, 1'b0, 32);
    check_cycles(32, "all_zero", 1'b0);

    // Mid-frame asynchronous reset; shadow returns to 0 so the first frame after release shows zeros.
    bus0.data_in = 32'h12345678;
    push_frame(32'h0, 4, 1'b0, 6);
    check_cycles(6, "pre_reset", 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    push_blank(1, 1'b0);
    compare_now("async_reset", 1'b0);
    @(posedge clk);
    #1;
    push_blank(1, 1'b0);
    compare_now("reset_mid", 1'b0);
    #2;
    rst_n = 1'b1;
    push_frame(32'h0, 4, 1'b0, 32);
    push_frame(32'h12345678, 4, 1'b0, 32);
    check_cycles(64, "post_reset", 1'b0);

    // DIV_CNT=1: one cycle per digit.
    bus0.en = 1'b0;
    bus1.data_in = 32'h89ABCDEF;
    @(posedge clk);
    #1;
    bus1.en = 1'b1;
    push_frame(32'h89ABCDEF, 1, 1'b1, 8);
    push_frame(32'h89ABCDEF, 1, 1'b1, 8);
    check_cycles(16, "div1_scan", 1'b1);
    bus1.en = 1'b0;
    push_blank(1, 1'b1);
    check_cycles(1, "div1_blank", 1'b1);

    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $error("FAIL queue_drain: observed=%0d/%0d leftover expected=0/0", exp_q.size(), exp1_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
